zoom_pool: RTL and testbench
============================

ZOOM_POOL -- requirements
Module: zoom_pool

Interface
REQ-001 Parameter IMG_W, default 1920, input pixels per line; SHALL be a multiple of 4.
REQ-002 Parameter IMG_H, default 1080, input lines per frame; SHALL be a multiple of 4.
REQ-003 Parameter DW, default 8, bits per colour channel.
REQ-004 Parameter CH, default 3, channel count; the pixel word is CH*DW bits, channel 0 in the LSBs.
REQ-005 Port clk, input, 1 bit: single clock, rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port vga_vs, input, 1 bit: while high, all frame state is held in reset and mode is sampled.
REQ-008 Port mode, input, 2 bits: 00 = pass-through, 01 = 2x2 average, 10 = 4x4 average, 11 = reserved.
REQ-009 Port din_vld, input, 1 bit: input pixel valid, raster order.
REQ-010 Port din, input, CH*DW bits: input pixel.
REQ-011 Port dout_vld, output, 1 bit: output pixel valid.
REQ-012 Port dout, output, CH*DW bits: pooled pixel.
REQ-013 Port dout_x, output, 12 bits: output column index.
REQ-014 Port dout_y, output, 12 bits: output row index.
REQ-015 Port frame_done, output, 1 bit: one-cycle pulse on the last output pixel of a frame.
REQ-016 Port err_ovf, output, 1 bit: sticky flag, set when a pixel arrives after IMG_W*IMG_H pixels in the frame.
REQ-017 Port err_mode, output, 1 bit: sticky flag, set when mode = 11 is latched.

Function
REQ-018 Pooling factor F SHALL be latched from mode on every clk while vga_vs = 1, and SHALL stay frozen while vga_vs = 0; reserved mode 11 SHALL set F = 1 and set err_mode.
REQ-019 Input column and row counters SHALL advance on din_vld only; the column wraps at IMG_W-1 and increments the row; both clear while vga_vs = 1.
REQ-020 Per channel, a horizontal accumulator SHALL sum F consecutive pixels with DW+4-bit width, so there is no overflow at F = 4.
REQ-021 A row-sum buffer of IMG_W/2 entries x CH*(DW+4) bits SHALL hold partial block sums.
- Entry index is col/F.
- First row of a block: write the horizontal sum.
- Intermediate rows: read-modify-write, adding the horizontal sum.
- Last row of a block: produce the output and do not write back.
REQ-022 Output per channel SHALL be (block_sum + F*F/2) >> log2(F*F), i.e. rounded-half-up, truncated to DW bits; F = 1 SHALL pass the pixel unchanged.
REQ-023 dout_vld SHALL assert exactly 2 clk cycles after the din_vld cycle that accepts the final pixel of a block (bottom-right), for every F including F = 1.
REQ-024 dout_x / dout_y SHALL equal (in_col/F, in_row/F) of that block, in the same cycle as dout_vld.
REQ-025 frame_done SHALL pulse in the cycle dout_vld is asserted for output (IMG_W/F-1, IMG_H/F-1).
REQ-026 Pixels beyond IMG_W*IMG_H in a frame SHALL be discarded (no output, no buffer write) and SHALL set err_ovf.
REQ-027 Gaps in din_vld (back-to-back or sparse) SHALL not alter results; the pipeline advances only on valid-tagged stages.
REQ-028 Read-modify-write to the same buffer entry on consecutive cycles SHALL be forwarded, so no stale sum is read.
REQ-029 vga_vs rising mid-frame SHALL drop in-flight blocks: no dout_vld and no frame_done after the cycle vga_vs is seen high.

Reset
REQ-030 While rst_n = 0, all of the following SHALL be 0 and F SHALL be 1:
- dout_vld, dout, dout_x, dout_y, frame_done, err_ovf, err_mode
- counters and accumulators
REQ-031 vga_vs = 1 SHALL act as a synchronous frame reset of counters, accumulators, pipeline valids, frame_done, err_ovf and err_mode; err_mode may then be re-set by the latched mode.
REQ-032 Row-sum buffer contents SHALL need no reset; the first-row write overwrites them.

Structure
REQ-033 Mode encodings, the DW+4 guard-bit constant and the factor/shift lookup SHALL live in shared package zoom_pkg.
REQ-034 Sub-module zoom_linebuf SHALL implement the row-sum buffer as a simple dual-port RAM with 1-cycle read latency and write-first forwarding.
REQ-035 The block SHALL be a single clock domain; the DDR-side FIFO and address generation stay outside it.

Verification (IMG_W=8, IMG_H=4, DW=8, CH=3)
REQ-036 Scenario 1: mode 01, all pixels 0x102030 -> 8 outputs of 0x102030, coordinates (0..3, 0..1), frame_done with output (3,1).
REQ-037 Scenario 2: mode 10, block values 0..15 on every channel -> output 0x080808 (sum 120, (120+8)>>4 = 8), 2 outputs total.
REQ-038 Scenario 3: mode 00, random pixels with random din_vld gaps -> dout equals din delayed 2 cycles; 32 outputs.
REQ-039 Scenario 4: mode 01, 33 pixels sent -> 33rd pixel is ignored, err_ovf = 1, exactly 8 outputs; next vga_vs clears err_ovf.
REQ-040 Scenario 5: vga_vs pulsed after 12 pixels in mode 10 -> no output in the cycles that follow; the next frame produces correct results.
REQ-041 Scenario 6: mode 11 latched -> err_mode = 1, pass-through behaviour; rst_n asserted mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/zoom_pkg.sv
// Shared constants for the zoom_pool downscaler: mode encodings, accumulator
// guard bits and the mode-to-pooling-factor lookup.
package zoom_pkg;

  typedef enum logic [1:0] {
    ModePass = 2'b00,
    ModeAvg2 = 2'b01,
    ModeAvg4 = 2'b10,
    ModeRsvd = 2'b11
  } mode_e;

  // Extra accumulator bits so a 4x4 block sum of full-scale pixels cannot overflow.
  localparam int unsigned GuardBits = 4;

  // Returns log2 of the pooling factor; the reserved mode falls back to F = 1.
  function automatic logic [1:0] mode_shift(input logic [1:0] mode);
    logic [1:0] shift;
    case (mode)
      ModeAvg2: shift = 2'd1;
      ModeAvg4: shift = 2'd2;
      default:  shift = 2'd0;
    endcase
    return shift;
  endfunction

endpackage

// File: rtl/zoom_linebuf.sv
// Row-sum buffer: simple dual-port RAM, 1-cycle read latency, write-first
// forwarding when a read hits the entry being written in the same cycle.
module zoom_linebuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents need no reset: the first row of every block overwrites its entry.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/zoom_pool.sv
// Frame downscaler: 1x1 / 2x2 / 4x4 box averaging with rounding, fixed
// two-cycle latency from the bottom-right pixel of a block to its output.
module zoom_pool
  import zoom_pkg::*;
#(
  parameter int unsigned IMG_W = 1920,
  parameter int unsigned IMG_H = 1080,
  parameter int unsigned DW    = 8,
  parameter int unsigned CH    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vga_vs,
  input  logic [1:0]       mode,
  input  logic             din_vld,
  input  logic [CH*DW-1:0] din,
  output logic             dout_vld,
  output logic [CH*DW-1:0] dout,
  output logic [11:0]      dout_x,
  output logic [11:0]      dout_y,
  output logic             frame_done,
  output logic             err_ovf,
  output logic             err_mode
);

  localparam int unsigned SW       = DW + GuardBits;
  localparam int unsigned DEPTH    = IMG_W / 2;
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [11:0] LAST_COL = 12'(IMG_W - 1);
  localparam logic [11:0] LAST_ROW = 12'(IMG_H - 1);

  logic [1:0]       fs_q;
  logic [11:0]      col_q, row_q;
  logic             full_q;
  logic [CH*SW-1:0] hacc_q;

  logic             s1_vld_q, s1_first_q, s1_last_row_q, s1_eof_q;
  logic [CH*SW-1:0] s1_hsum_q;
  logic [AW-1:0]    s1_idx_q;
  logic [11:0]      s1_x_q, s1_y_q;

  logic             accept, first_col, hdone, first_row, last_row, last_pix, re, we;
  logic [1:0]       mask;
  logic [SW-1:0]    half;
  logic [AW-1:0]    raddr;
  logic [CH*SW-1:0] hsum, rdata, blk_sum;
  logic [CH*DW-1:0] pooled;

  always_comb begin
    unique case (fs_q)
      2'd1:    begin mask = 2'b01; half = SW'(2); end
      2'd2:    begin mask = 2'b11; half = SW'(8); end
      default: begin mask = 2'b00; half = '0;     end
    endcase
    accept    = din_vld && !vga_vs && !full_q;
    first_col = (col_q[1:0] & mask) == 2'b00;
    hdone     = (col_q[1:0] & mask) == mask;
    first_row = (row_q[1:0] & mask) == 2'b00;
    last_row  = (row_q[1:0] & mask) == mask;
    last_pix  = (col_q == LAST_COL) && (row_q == LAST_ROW);
    // F = 1 never touches the buffer: every pixel is its own complete block.
    re        = accept && hdone && (fs_q != 2'd0);
    raddr     = AW'(col_q >> fs_q);
    we        = s1_vld_q && !s1_last_row_q;
    hsum      = '0;
    blk_sum   = '0;
    pooled    = '0;
    for (int c = 0; c < CH; c++) begin
      hsum[c*SW +: SW]    = (first_col ? {SW{1'b0}} : hacc_q[c*SW +: SW])
                            + SW'(din[c*DW +: DW]);
      blk_sum[c*SW +: SW] = s1_first_q ? s1_hsum_q[c*SW +: SW]
                                       : rdata[c*SW +: SW] + s1_hsum_q[c*SW +: SW];
      pooled[c*DW +: DW]  = DW'((blk_sum[c*SW +: SW] + half) >> {fs_q, 1'b0});
    end
  end

  zoom_linebuf #(
    .DEPTH (DEPTH),
    .WIDTH (CH * SW),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (we),
    .waddr (s1_idx_q),
    .wdata (blk_sum),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q          <= 2'd0;
      col_q         <= '0;
      row_q         <= '0;
      full_q        <= 1'b0;
      hacc_q        <= '0;
      s1_vld_q      <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_row_q <= 1'b0;
      s1_eof_q      <= 1'b0;
      s1_hsum_q     <= '0;
      s1_idx_q      <= '0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      dout_vld      <= 1'b0;
      dout          <= '0;
      dout_x        <= '0;
      dout_y        <= '0;
      frame_done    <= 1'b0;
      err_ovf       <= 1'b0;
      err_mode      <= 1'b0;
    end else if (vga_vs) begin
      // Frame reset; the pooling factor tracks mode only during blanking.
      fs_q       <= mode_shift(mode);
      err_mode   <= (mode == ModeRsvd);
      col_q      <= '0;
      row_q      <= '0;
      full_q     <= 1'b0;
      hacc_q     <= '0;
      s1_vld_q   <= 1'b0;
      dout_vld   <= 1'b0;
      frame_done <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      if (din_vld && full_q) begin
        err_ovf <= 1'b1;
      end
      if (accept) begin
        hacc_q <= hsum;
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + 12'd1;
        end else begin
          col_q <= col_q + 12'd1;
        end
        if (last_pix) begin
          full_q <= 1'b1;
        end
      end
      s1_vld_q <= accept && hdone;
      if (accept && hdone) begin
        s1_hsum_q     <= hsum;
        s1_idx_q      <= raddr;
        s1_first_q    <= first_row;
        s1_last_row_q <= last_row;
        s1_eof_q      <= last_pix;
        s1_x_q        <= col_q >> fs_q;
        s1_y_q        <= row_q >> fs_q;
      end
      dout_vld   <= s1_vld_q && s1_last_row_q;
      frame_done <= s1_vld_q && s1_last_row_q && s1_eof_q;
      if (s1_vld_q && s1_last_row_q) begin
        dout   <= pooled;
        dout_x <= s1_x_q;
        dout_y <= s1_y_q;
      end
    end
  end

endmodule

// File: tb/tb_zoom_pool.sv
// Randomized bench for zoom_pool on an 8x4 frame: a whole-frame reference
// model predicts each pooled pixel, its coordinates and its arrival cycle.
module tb_zoom_pool;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n, vga_vs, din_vld;
  logic [1:0]  mode;
  logic [23:0] din;
  logic        dout_vld, frame_done, err_ovf, err_mode;
  logic [23:0] dout;
  logic [11:0] dout_x, dout_y;

  zoom_pool #(
    .IMG_W (W),
    .IMG_H (H),
    .DW    (8),
    .CH    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_vs     (vga_vs),
    .mode       (mode),
    .din_vld    (din_vld),
    .din        (din),
    .dout_vld   (dout_vld),
    .dout       (dout),
    .dout_x     (dout_x),
    .dout_y     (dout_y),
    .frame_done (frame_done),
    .err_ovf    (err_ovf),
    .err_mode   (err_mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] d;
    bit          last;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [23:0] pix [H][W];
  int          f_m = 1;
  int          pcount = 0;
  bit          exp_ovf = 0;
  bit          exp_merr = 0;
  int          n_out = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n0;
  logic [23:0] last_dout = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: store the frame, and when a block's bottom-right pixel lands
  // average the whole block straight from the stored pixels.
  task automatic model_accept(input logic [23:0] d);
    int          r, c, s, avg;
    logic [23:0] p;
    exp_t        e;
    if (pcount >= W * H) begin
      exp_ovf = 1;
      return;
    end
    r = pcount / W;
    c = pcount % W;
    pix[r][c] = d;
    pcount++;
    if ((c % f_m) == f_m - 1 && (r % f_m) == f_m - 1) begin
      e.d = '0;
      for (int ch = 0; ch < 3; ch++) begin
        s = 0;
        for (int dy = 0; dy < f_m; dy++) begin
          for (int dx = 0; dx < f_m; dx++) begin
            p = pix[r - dy][c - dx];
            s += int'(p[ch*8 +: 8]);
          end
        end
        avg = (s + (f_m * f_m) / 2) / (f_m * f_m);
        e.d[ch*8 +: 8] = 8'(avg);
      end
      e.due  = cyc + 2;
      e.x    = 12'(c / f_m);
      e.y    = 12'(r / f_m);
      e.last = (c == W - 1) && (r == H - 1);
      q.push_back(e);
    end
  endtask

  task automatic drive(input bit v, input logic [23:0] d);
    @(posedge clk);
    #1;
    din_vld = v;
    din     = d;
    if (v) model_accept(d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 24'($urandom));
  endtask

  task automatic send(input logic [23:0] d, input int gapmax);
    if (gapmax > 0) idle($urandom_range(0, gapmax));
    drive(1'b1, d);
  endtask

  task automatic frame_start(input logic [1:0] m);
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    vga_vs  = 1'b1;
    mode    = m;
    // Blocks that would surface after this cycle are dropped by the frame reset.
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    pcount   = 0;
    exp_ovf  = 0;
    exp_merr = (m == 2'b11);
    f_m      = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    @(posedge clk);
    #1;
    vga_vs = 1'b0;
  endtask

  task automatic random_frame(input int gapmax);
    for (int i = 0; i < W * H; i++) send(24'($urandom), gapmax);
    idle(4);
    check("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_vld) begin
        n_out++;
        last_dout = dout;
        if (q.size() == 0) begin
          check("spurious_vld", 1, 0);
        end else begin
          me = q.pop_front();
          check("latency", cyc, me.due);
          check("dout", dout, me.d);
          check("dout_x", dout_x, me.x);
          check("dout_y", dout_y, me.y);
          check("frame_done", frame_done, me.last);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing_vld", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    vga_vs  = 1'b0;
    mode    = 2'b00;
    din_vld = 1'b0;
    din     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", dout_vld, 0);
    check("rst_dout", dout, 0);
    check("rst_x", dout_x, 0);
    check("rst_y", dout_y, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ovf", err_ovf, 0);
    check("rst_merr", err_mode, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2x2 on a flat field
    frame_start(2'b01);
    n0 = n_out;
    for (int i = 0; i < W * H; i++) send(24'h102030, 0);
    idle(4);
    check("s1_count", n_out - n0, 8);
    check("s1_value", last_dout, 24'h102030);

    // 4x4 on a 0..15 ramp inside each block
    frame_start(2'b10);
    n0 = n_out;
    for (int i = 0; i < W * H; i++) begin
      logic [7:0] b;
      b = 8'(((i / W) % 4) * 4 + (i % W) % 4);
      send({b, b, b}, 0);
    end
    idle(4);
    check("s2_count", n_out - n0, 2);
    check("s2_value", last_dout, 24'h080808);

    // Pass-through with sparse valid
    frame_start(2'b00);
    n0 = n_out;
    random_frame(3);
    check("s3_count", n_out - n0, 32);

    // Overflow pixel
    frame_start(2'b01);
    n0 = n_out;
    for (int i = 0; i < W * H + 1; i++) send(24'($urandom), 1);
    idle(4);
    check("s4_count", n_out - n0, 8);
    check("s4_ovf", err_ovf, exp_ovf);
    frame_start(2'b01);
    check("s4_ovf_clr", err_ovf, 0);

    // Frame reset mid-frame, 4x4 then 2x2 with a block in flight
    frame_start(2'b10);
    for (int i = 0; i < 12; i++) send(24'($urandom), 1);
    frame_start(2'b10);
    n0 = n_out;
    idle(6);
    check("s5_quiet", n_out - n0, 0);
    random_frame(2);
    check("s5_count", n_out - n0, 2);
    frame_start(2'b01);
    for (int i = 0; i < 10; i++) send(24'($urandom), 0);
    frame_start(2'b01);
    n0 = n_out;
    idle(6);
    check("s5_drop", n_out - n0, 0);
    random_frame(1);
    check("s5_count2", n_out - n0, 8);

    // Reserved mode, then asynchronous reset mid-frame
    frame_start(2'b11);
    check("s6_merr", err_mode, exp_merr);
    n0 = n_out;
    for (int i = 0; i < 16; i++) send(24'($urandom), 1);
    idle(3);
    check("s6_count", n_out - n0, 16);
    drive(1'b1, 24'($urandom));
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("s6_vld", dout_vld, 0);
    check("s6_dout", dout, 0);
    check("s6_x", dout_x, 0);
    check("s6_y", dout_y, 0);
    check("s6_fd", frame_done, 0);
    check("s6_ovf", err_ovf, 0);
    check("s6_merr_rst", err_mode, 0);
    din_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random modes and gaps
    for (int k = 0; k < 4; k++) begin
      frame_start(2'($urandom_range(0, 2)));
      n0 = n_out;
      random_frame(k);
      check("rand_count", n_out - n0, (W / f_m) * (H / f_m));
      check("rand_merr", err_mode, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
